bits_regs_mc: RTL
=================

# bits_regs_mc

Multi-channel APB3 register file for the BITS decoder array. It gives software independent start, expected-byte and result registers for `NUM_CH` BITS cores. Each channel has sticky W1C done status, a masked interrupt, a busy flag and an optional start-to-done cycle counter. The block sits between the APB fabric and the array of BITS cores, and it flags bad accesses with `pslverr`.

## Interface
- `NUM_CH`, 4: number of BITS cores served (legal 1..7).
- `VAL_W`, 64: width of each core's result value (legal 33..64).
- `clk` input 1: system clock; all state updates on rising edge.
- `resetB` input 1: asynchronous active-low reset.
- `paddr` input [7:2]: word address.
- `psel`, `penable`, `pwrite` input 1 each: APB3 control.
- `pwdata` input 32: write data.
- `pready` output 1: tied 1, no wait states.
- `prdata` output 32: read data, combinational, valid during the access phase.
- `pslverr` output 1: error on a bad access, combinational, access phase only.
- `done` input NUM_CH: per-core done, single-cycle pulse or level.
- `bits_value` input NUM_CH*VAL_W: channel c occupies [c*VAL_W +: VAL_W].
- `version_sum` input NUM_CH*16: per-core version sum.
- `bit_counter` input NUM_CH*16: per-core live bit counter.
- `start` output NUM_CH: per-core one-cycle start pulse.
- `expected_bytes` output NUM_CH*16: per-core byte count.
- `irq` output 1: OR of (STATUS & IRQ_EN).

## Operation
- Write strobe is `psel & penable & pwrite`; read strobe is `psel & penable & ~pwrite`. No state changes outside the access phase.
- **Global word map**
  - 0x00 CTRL, WO: writing bit c=1 pulses `start[c]`; reads 0.
  - 0x01 STATUS, RW: [NUM_CH-1:0] sticky done, write 1 to clear; [NUM_CH+7:8] busy, RO.
  - 0x02 IRQ_EN, RW: [NUM_CH-1:0].
  - 0x03 ID, RO: {8'hB1, 8'(NUM_CH), 16'(VAL_W)}.
- **Per-channel word map**, base b = 8*(c+1):
  - b+0 EXP_BYTES, RW [15:0].
  - b+1 VSUM, latched, RO.
  - b+2 BITCNT, live `bit_counter`, RO.
  - b+3 VAL_HI, RO: latched value bits above 32, zero-extended.
  - b+4 VAL_LO, RO: latched value [31:0].
  - b+5 ELAPSED, RO, 32 bits.
  - b+6 and b+7 are reserved.
- **pslverr = 1** in any of these cases; reads then return 0 and writes are dropped:
  - reserved or unmapped word;
  - channel index >= NUM_CH;
  - write to an RO word.
- **Per-channel state machine**
  - IDLE: on `start[c]`, clear VSUM, VAL and ELAPSED, clear done_c, set busy_c, go to RUN.
  - RUN: ELAPSED increments by 1 each cycle and saturates at 32'hFFFF_FFFF. On `done[c]`, capture `version_sum` and `bits_value`, set done_c, clear busy_c, freeze ELAPSED, go to IDLE.
  - `done[c]` while IDLE is ignored.
  - `start[c]` while RUN restarts the channel: clear and stay in RUN.
- **Simultaneous events**
  - `start[c]` and `done[c]` in the same cycle: start wins.
  - A W1C write and a done capture on the same bit in the same cycle: set wins.
- **Reset values** (everything 0):
  - `start`, `expected_bytes`, STATUS, IRQ_EN, VSUM, VAL, ELAPSED and `irq` are 0.
  - All channels are in IDLE.
  - `pready` is 1.
  - `prdata` and `pslverr` are 0 when idle.
  - Reset asserted mid-RUN returns the channel to IDLE immediately.

## Timing
- A CTRL write access phase in cycle T drives `start[c]` high for exactly cycle T+1; busy_c reads 1 from T+2.
- `done[c]` sampled at edge D sets done_c and clears busy_c, visible from D+1.
- `irq` rises in D+1 if enabled. It falls the cycle after the W1C access phase, or after the IRQ_EN bit is cleared.
- ELAPSED = D - (T+1): the number of cycles from the start pulse to the done sample.
- EXP_BYTES writes are visible on `expected_bytes` from the next cycle.
- Zero-latency read: `prdata` reflects register state in the access-phase cycle.

## Configuration
- `BITS_REGS_ELAPSED_EN` defined: the ELAPSED counters are compiled in, one 32-bit counter per channel.
- Undefined: no counters. ELAPSED reads 32'h0 with `pslverr` = 0, and writes to it still raise `pslverr`.

## Test plan
- **Reset**: after reset release, read ID with NUM_CH=4 and VAL_W=64 → 32'hB104_0040. STATUS, IRQ_EN and all VSUM/VAL read 0.
- **Single channel**:
  - Stimulus: write EXP_BYTES ch2 = 16'h0123; write CTRL = 32'h4; pulse `done[2]` 10 cycles after the start pulse with VAL = 64'hDEAD_BEEF_0000_0007 and VSUM = 16'h0010.
  - Response: `start` = 4'b0100 for one cycle; STATUS = 32'h4; VAL_HI = 32'hDEAD_BEEF; VAL_LO = 7; VSUM = 16; ELAPSED = 10.
- **Interrupt and W1C**: IRQ_EN = 4'hF, then ch0 completes → `irq` = 1. Write STATUS = 1 → `irq` = 0 next cycle. Writing STATUS = 0 leaves the bits unchanged.
- **Collisions**:
  - `start[1]` and `done[1]` in the same cycle → channel stays busy, nothing captured.
  - W1C on bit 3 in the same cycle as a `done[3]` capture → bit 3 remains 1.
- **Errors**: each of these → `pslverr` = 1, `prdata` = 0, no state change:
  - read word 0x06;
  - read ch4 base 0x28 with NUM_CH=4;
  - write VSUM of ch0.
- **Restart and reset**:
  - Restart ch1 mid-RUN → ELAPSED restarts from 0.
  - Assert `resetB` low mid-RUN → busy cleared asynchronously, all outputs 0.

Source files
------------

// File: rtl/bits_regs_mc.sv
// bits_regs_mc: APB3 register file driving NUM_CH BITS cores with start/done tracking.
// Define BITS_REGS_ELAPSED_EN to build the per-channel start-to-done cycle counters.
module bits_regs_mc #(
  parameter int NUM_CH = 4,
  parameter int VAL_W  = 64
) (
  input  logic                    clk,
  input  logic                    resetB,
  input  logic [7:2]              paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [31:0]             pwdata,
  output logic                    pready,
  output logic [31:0]             prdata,
  output logic                    pslverr,
  input  logic [NUM_CH-1:0]       done,
  input  logic [NUM_CH*VAL_W-1:0] bits_value,
  input  logic [NUM_CH*16-1:0]    version_sum,
  input  logic [NUM_CH*16-1:0]    bit_counter,
  output logic [NUM_CH-1:0]       start,
  output logic [NUM_CH*16-1:0]    expected_bytes,
  output logic                    irq
);
  typedef enum logic {IDLE, RUN} st_t;
  st_t               st     [NUM_CH];
  logic [15:0]       exp_q  [NUM_CH];
  logic [15:0]       vsum_q [NUM_CH];
  logic [VAL_W-1:0]  val_q  [NUM_CH];
  logic [31:0]       ela_v  [NUM_CH];
  logic [NUM_CH-1:0] start_q, sts, ien, busy;
  logic [2:0]        blk, off;
  logic              acc, glb, mapped, ro, err, wr_ok, gw;
  logic [31:0]       rdat;
  logic              unused_ok;
  assign blk       = paddr[7:5];
  assign off       = paddr[4:2];
  assign acc       = psel & penable;
  assign glb       = blk == 3'd0;
  assign mapped    = glb ? ~off[2] : (32'(blk) <= NUM_CH) && (off < 3'd6);
  assign ro        = glb ? off == 3'd3 : off != 3'd0;
  assign err       = acc & (~mapped | (pwrite & ro));
  assign wr_ok     = acc & pwrite & ~err;
  assign gw        = wr_ok & glb;
  assign pready    = 1'b1;
  assign pslverr   = err;
  assign prdata    = (acc & ~pwrite & ~err) ? rdat : '0;
  assign start     = start_q;
  assign irq       = |(sts & ien);
  assign unused_ok = ^pwdata[31:16];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign busy[g]                  = st[g] == RUN;
    assign expected_bytes[g*16+:16] = exp_q[g];
  end
  always_comb begin
    rdat = glb ? (off == 3'd1 ? 32'({8'(busy), 8'(sts)}) :
                  off == 3'd2 ? 32'(ien) :
                  off == 3'd3 ? {8'hB1, 8'(NUM_CH), 16'(VAL_W)} : '0) : '0;
    for (int c = 0; c < NUM_CH; c++)
      if (32'(blk) == 32'(c + 1))
        rdat = off == 3'd0 ? 32'(exp_q[c]) :
               off == 3'd1 ? 32'(vsum_q[c]) :
               off == 3'd2 ? 32'(bit_counter[c*16 +: 16]) :
               off == 3'd3 ? 32'(val_q[c] >> 32) :
               off == 3'd4 ? val_q[c][31:0] :
               off == 3'd5 ? ela_v[c] : '0;
  end
  always_ff @(posedge clk or negedge resetB)
    if (!resetB) begin
      start_q <= '0;
      sts     <= '0;
      ien     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        st[c]     <= IDLE;
        exp_q[c]  <= '0;
        vsum_q[c] <= '0;
        val_q[c]  <= '0;
      end
    end else begin
      start_q <= (gw && off == 3'd0) ? pwdata[NUM_CH-1:0] : '0;
      if (gw && off == 3'd2) ien <= pwdata[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok && 32'(blk) == 32'(c + 1) && off == 3'd0) exp_q[c] <= pwdata[15:0];
        // start beats a same-cycle done, and a done capture beats a same-cycle W1C
        if (start_q[c]) begin
          st[c]     <= RUN;
          sts[c]    <= 1'b0;
          vsum_q[c] <= '0;
          val_q[c]  <= '0;
        end else if (st[c] == RUN && done[c]) begin
          st[c]     <= IDLE;
          sts[c]    <= 1'b1;
          vsum_q[c] <= version_sum[c*16 +: 16];
          val_q[c]  <= bits_value[c*VAL_W +: VAL_W];
        end else if (gw && off == 3'd1 && pwdata[c]) begin
          sts[c] <= 1'b0;
        end
      end
    end
`ifdef BITS_REGS_ELAPSED_EN
  logic [31:0] ela_q [NUM_CH];
  always_ff @(posedge clk or negedge resetB)
    if (!resetB) begin
      for (int c = 0; c < NUM_CH; c++) ela_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (start_q[c]) ela_q[c] <= '0;
        else if (busy[c] && !(&ela_q[c])) ela_q[c] <= ela_q[c] + 32'd1;
    end
  always_comb
    for (int c = 0; c < NUM_CH; c++) ela_v[c] = ela_q[c];
`else
  always_comb
    for (int c = 0; c < NUM_CH; c++) ela_v[c] = '0;
`endif
endmodule
